modexp_scheduler: RTL and testbench
===================================

# modexp_scheduler

Shares one modular-exponentiation engine between two requesters of the Diffie-Hellman key exchange: port 0 computes the local public key (g^a mod p) and port 1 computes the shared secret (B^a mod p). The scheduler runs round-robin arbitration and latches operands. It sequences the engine's load/run/done protocol, guards each run with a watchdog, and returns each result to its owner over a valid/ready handshake. It sits between the key-exchange control logic and the single engine instance.

## Interface
- WIDTH, 100, operand/modulus width; exponent is WIDTH+1 bits
- TIMEOUT, 2**16-1, max engine cycles per job before abort
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- prime  in  WIDTH  modulus, sampled at grant
- req_valid[1:0]  in  2  per-port request
- req_ready[1:0]  out  2  per-port accept; a request transfers on valid&&ready
- req_base0/1  in  WIDTH  base per port
- req_exp0/1  in  WIDTH+1  exponent per port
- rsp_valid[1:0]  out  2  result valid, one-hot, to the owning port
- rsp_ready[1:0]  in  2  per-port result accept
- rsp_result  out  WIDTH  shared result bus
- rsp_err  out  1  qualifies rsp_result: 1 = watchdog abort, result forced 0
- eng_start  out  1  one-cycle pulse that (re)loads the engine
- eng_base, eng_prime  out  WIDTH  held stable from eng_start until job end
- eng_exp  out  WIDTH+1  held stable likewise
- eng_busy  in  1  engine computing (engine "dirty" flag)
- eng_result  in  WIDTH  valid when eng_busy falls

## Operation
- States: IDLE, START, ARM, RUN, RESP.
- IDLE: grant = one requesting port; on conflict, the port not served last wins (last_grant resets to 1, so port 0 wins first). req_ready is high only for the granted port, and only in IDLE.
- On transfer: latch base, exp, prime, owner, and clear the watchdog counter.
  - exp==0: result=1, go to RESP without touching the engine.
  - Otherwise go to START.
- START: eng_start=1 for exactly one cycle, then ARM.
- ARM: wait for eng_busy=1, which absorbs the engine's one-cycle load latency. If eng_busy is not seen within 2 cycles, the job completes immediately: capture eng_result and go to RESP.
- RUN: watchdog increments each cycle.
  - eng_busy=0: capture eng_result, rsp_err=0, go to RESP.
  - Watchdog == TIMEOUT: result=0, rsp_err=1, go to RESP. The engine is left running; the next eng_start reloads it.
- RESP: rsp_valid[owner]=1 with rsp_result/rsp_err held stable until rsp_ready[owner]. On that transfer: last_grant=owner, go to IDLE.
- Only one job is in flight at a time; there is no queueing beyond the requester's own valid hold.
- Widths: result WIDTH bits, no reduction performed by the scheduler. Watchdog is clog2(TIMEOUT+1) bits and saturates.

## Timing
- Reset values: state=IDLE, req_ready=0 during reset, rsp_valid=0, rsp_result=0, rsp_err=0, eng_start=0, eng_* operand regs=0, last_grant=1.
- Accept at cycle T → eng_start at T+1 → ARM from T+2.
- eng_busy falls at cycle F → rsp_valid at F+1.
- exp==0: rsp_valid at T+1.
- Best-case turnaround: a new grant is possible the cycle after the response transfer.
- req_valid dropping before acceptance cancels that request cleanly; it is never latched.
- Reset asserted mid-job: all state is cleared immediately and no response is produced. The engine is not reset by this block; its own reset/start handles that.
- rsp_ready asserted on a non-owner port is ignored.

## Structure
- Shared package dh_pkg holds WIDTH default, state enum modexp_sched_state_t, and the TIMEOUT default.
- One natural sub-module, rr_arbiter2: 2-way round-robin with last_grant register. It is combinational grant plus a 1-bit state update on an enable.

## Test plan
- Single request, port 0: base=2, exp=10, prime=1000003, engine model returns 1024 after 12 busy cycles → rsp_valid[0] 13 cycles after eng_start's ARM, rsp_result=1024, rsp_err=0.
- Simultaneous req_valid=2'b11 out of reset → port 0 served first, port 1 next. Repeat with both held → grants alternate 0,1,0,1.
- exp=0 on port 1 → no eng_start pulse, rsp_valid[1] next cycle with rsp_result=1.
- Engine busy stuck high with TIMEOUT=20 → rsp_err=1, rsp_result=0 after 20 RUN cycles. The next job still issues eng_start and completes normally.
- rsp_ready withheld 5 cycles → rsp_valid and rsp_result stable throughout, req_ready stays 0 for both ports.
- rst asserted during RUN → all outputs at reset values in the same cycle. After release, a fresh request on port 1 completes correctly.

Source files
------------

// File: rtl/dh_pkg.sv
// Shared Diffie-Hellman definitions: default widths,
// watchdog limit and the scheduler state encoding.
package dh_pkg;

   localparam int DH_WIDTH   = 100;
   localparam int DH_TIMEOUT = 2**16 - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ARM,
      S_RUN,
      S_RESP
   } modexp_sched_state_t;

endpackage

// File: rtl/modexp_scheduler_if.sv
// Requester-side bundle of the modexp scheduler: two request
// ports with operands plus the shared one-hot response path.
interface modexp_scheduler_if #(
   parameter int WIDTH = dh_pkg::DH_WIDTH
);

   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] req_base0;
   logic [WIDTH-1:0] req_base1;
   logic [WIDTH:0]   req_exp0;
   logic [WIDTH:0]   req_exp1;
   logic [WIDTH-1:0] prime;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_err;

   modport master (
      output req_valid, req_base0, req_base1,
      output req_exp0, req_exp1, prime, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_err
   );

   modport slave (
      input  req_valid, req_base0, req_base1,
      input  req_exp0, req_exp1, prime, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_err
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the port not served last wins
// a conflict. last_grant only moves when en is asserted.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   input  logic       id,
   output logic [1:0] gnt
);

   logic last_grant;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_grant <= 1'b1;
      else if (en)
         last_grant <= id;
   end

   always_comb begin
      gnt = 2'b00;
      unique case (1'b1)
         (req == 2'b11): gnt = last_grant ? 2'b01 : 2'b10;
         (req == 2'b01): gnt = 2'b01;
         (req == 2'b10): gnt = 2'b10;
         default:        gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/modexp_scheduler.sv
// Shares one modexp engine between two DH requesters: arbitrates,
// latches operands, sequences load/run/done and guards each run.
module modexp_scheduler
   import dh_pkg::*;
#(
   parameter int WIDTH   = DH_WIDTH,
   parameter int TIMEOUT = DH_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   modexp_scheduler_if.slave bus,
   output logic             eng_start,
   output logic [WIDTH-1:0] eng_base,
   output logic [WIDTH-1:0] eng_prime,
   output logic [WIDTH:0]   eng_exp,
   input  logic             eng_busy,
   input  logic [WIDTH-1:0] eng_result
);

   localparam int WDW = $clog2(TIMEOUT + 1);

   modexp_sched_state_t state, state_n;

   logic [1:0]       gnt;
   logic             sel;
   logic             take;
   logic             done_ack;
   logic             owner;
   logic             arm_wait;
   logic             wd_hit;
   logic             err;
   logic [WDW-1:0]   wdog;
   logic [WDW-1:0]   wd_nxt;
   logic [WIDTH-1:0] sel_base;
   logic [WIDTH:0]   sel_exp;
   logic [WIDTH-1:0] result;

   rr_arbiter2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (bus.req_valid),
      .en  (done_ack),
      .id  (owner),
      .gnt (gnt)
   );

   assign sel      = gnt[1];
   assign sel_base = sel ? bus.req_base1 : bus.req_base0;
   assign sel_exp  = sel ? bus.req_exp1 : bus.req_exp0;
   assign take     = |(bus.req_valid & bus.req_ready);
   assign done_ack = |(bus.rsp_valid & bus.rsp_ready);

   // Saturating count; wd_hit flags the cycle it reaches TIMEOUT.
   assign wd_nxt = (&wdog) ? wdog : wdog + 1'b1;
   assign wd_hit = (wd_nxt == WDW'(TIMEOUT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: begin
            if (take)
               state_n = (sel_exp == '0) ? S_RESP : S_START;
         end
         S_START: state_n = S_ARM;
         S_ARM: begin
            if (eng_busy)
               state_n = S_RUN;
            else if (arm_wait)
               state_n = S_RESP;
         end
         S_RUN: begin
            if (!eng_busy || wd_hit)
               state_n = S_RESP;
         end
         S_RESP: begin
            if (done_ack)
               state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // req_ready is gated by rst so nothing is offered while held in reset.
   always_comb begin
      eng_start     = (state == S_START);
      bus.req_ready = 2'b00;
      bus.rsp_valid = 2'b00;
      if (state == S_IDLE && rst)
         bus.req_ready = gnt;
      if (state == S_RESP)
         bus.rsp_valid = owner ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner     <= 1'b0;
         arm_wait  <= 1'b0;
         wdog      <= '0;
         result    <= '0;
         err       <= 1'b0;
         eng_base  <= '0;
         eng_exp   <= '0;
         eng_prime <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (take) begin
                  owner    <= sel;
                  wdog     <= '0;
                  arm_wait <= 1'b0;
                  err      <= 1'b0;
                  if (sel_exp == '0) begin
                     result <= WIDTH'(1);
                  end else begin
                     eng_base  <= sel_base;
                     eng_exp   <= sel_exp;
                     eng_prime <= bus.prime;
                  end
               end
            end
            S_ARM: begin
               arm_wait <= 1'b1;
               if (!eng_busy && arm_wait)
                  result <= eng_result;
            end
            S_RUN: begin
               wdog <= wd_nxt;
               if (!eng_busy) begin
                  result <= eng_result;
                  err    <= 1'b0;
               end else if (wd_hit) begin
                  result <= '0;
                  err    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rsp_result = result;
   assign bus.rsp_err    = err;

endmodule

// File: tb/tb_modexp_scheduler.sv
// Scoreboard bench for modexp_scheduler with a behavioural engine
// whose busy length and stuck state are set per test.
module tb_modexp_scheduler;

   localparam int W = 100;

   typedef struct {
      bit          port;
      logic [W-1:0] res;
      bit          err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         eng_start;
   logic [W-1:0] eng_base;
   logic [W-1:0] eng_prime;
   logic [W:0]   eng_exp;
   logic         eng_busy;
   logic [W-1:0] eng_result = '0;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_start = 0;
   int   start_cyc = 0;
   int   acc_cyc = 0;
   int   busy_len = 12;
   bit   stuck = 1'b0;
   int   ecnt = 0;
   exp_t sb[$];

   modexp_scheduler_if #(.WIDTH(W)) bus ();

   modexp_scheduler #(.WIDTH(W), .TIMEOUT(20)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .eng_start  (eng_start),
      .eng_base   (eng_base),
      .eng_prime  (eng_prime),
      .eng_exp    (eng_exp),
      .eng_busy   (eng_busy),
      .eng_result (eng_result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [W-1:0] mexp(
      logic [W-1:0] b, logic [W:0] e, logic [W-1:0] p);
      logic [255:0] r;
      logic [255:0] bb;
      r  = 256'd1;
      bb = {156'd0, b} % {156'd0, p};
      for (int i = W; i >= 0; i--) begin
         r = (r * r) % {156'd0, p};
         if (e[i])
            r = (r * bb) % {156'd0, p};
      end
      return r[W-1:0];
   endfunction

   // Engine: busy one cycle after load, for busy_len cycles.
   always @(posedge clk) begin
      if (eng_start) begin
         ecnt       <= busy_len;
         eng_result <= mexp(eng_base, eng_exp, eng_prime);
      end else if (ecnt != 0) begin
         ecnt <= ecnt - 1;
      end
   end

   assign eng_busy = stuck || (ecnt != 0);

   always @(negedge clk) begin
      if (eng_start) begin
         n_start++;
         start_cyc = cyc;
      end
   end

   function automatic void chk(
      string nm, logic [127:0] act, logic [127:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, want);
      end
   endfunction

   function automatic void push(bit p, logic [W-1:0] r, bit e);
      exp_t x;
      x.port = p;
      x.res  = r;
      x.err  = e;
      sb.push_back(x);
   endfunction

   // Monitor: compares every response transfer against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst && (bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected: got valid=%b expected none",
                     bus.rsp_valid);
         end else begin
            e = sb.pop_front();
            chk("rsp_port", 128'(bus.rsp_valid),
                e.port ? 128'd2 : 128'd1);
            chk("rsp_result", 128'(bus.rsp_result), 128'(e.res));
            chk("rsp_err", 128'(bus.rsp_err), 128'(e.err));
         end
      end
   end

   task automatic do_req(int p, logic [W-1:0] b, logic [W:0] e,
                         logic [W-1:0] pr);
      bit got;
      got = 1'b0;
      @(posedge clk);
      #1;
      bus.prime = pr;
      if (p == 0) begin
         bus.req_base0 = b;
         bus.req_exp0  = e;
      end else begin
         bus.req_base1 = b;
         bus.req_exp1  = e;
      end
      bus.req_valid[p] = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready[p]) begin
            got     = 1'b1;
            acc_cyc = cyc;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept%0d: got timeout expected grant", p);
      end
      @(posedge clk);
      #1;
      bus.req_valid[p] = 1'b0;
   endtask

   task automatic wait_valid(int p);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (bus.rsp_valid[p])
            got = 1'b1;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_rsp%0d: got timeout expected valid", p);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++)
         @(negedge clk);
      chk("drain", 128'(sb.size()), 128'd0);
   endtask

   initial begin
      int n;
      int ns;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      bus.prime     = 100'd1000003;
      bus.req_base0 = 100'd3;
      bus.req_exp0  = 101'd5;
      bus.req_base1 = 100'd7;
      bus.req_exp1  = 101'd2;
      busy_len      = 3;

      // Reset values, with both ports already requesting.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 128'(bus.req_ready), 128'd0);
      chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
      chk("rst_eng_start", 128'(eng_start), 128'd0);
      chk("rst_result", 128'(bus.rsp_result), 128'd0);
      chk("rst_err", 128'(bus.rsp_err), 128'd0);
      chk("rst_eng_base", 128'(eng_base), 128'd0);
      chk("rst_eng_exp", 128'(eng_exp), 128'd0);

      // Both held out of reset: grants 0,1,0,1.
      push(0, 100'd243, 0);
      push(1, 100'd49, 0);
      push(0, 100'd243, 0);
      push(1, 100'd49, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 400 && n < 4; i++) begin
         @(negedge clk);
         if ((bus.req_valid & bus.req_ready) != 2'b00) begin
            chk("grant_order", 128'(bus.req_ready[1]),
                128'(n % 2));
            n++;
         end
      end
      chk("grant_count", 128'(n), 128'd4);
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      wait_drain();

      // Single port-0 job, 12 busy cycles.
      busy_len = 12;
      push(0, 100'd1024, 0);
      do_req(0, 100'd2, 101'd10, 100'd1000003);
      wait_valid(0);
      chk("t1_latency", 128'(cyc - start_cyc), 128'd14);
      wait_drain();

      // exp==0 on port 1 bypasses the engine.
      ns = n_start;
      push(1, 100'd1, 0);
      do_req(1, 100'd9, 101'd0, 100'd1000003);
      wait_valid(1);
      chk("exp0_latency", 128'(cyc - acc_cyc), 128'd1);
      wait_drain();
      chk("exp0_no_start", 128'(n_start), 128'(ns));

      // Stuck engine trips the watchdog after 20 RUN cycles.
      stuck    = 1'b1;
      busy_len = 2;
      push(0, 100'd0, 1);
      do_req(0, 100'd5, 101'd3, 100'd97);
      wait_valid(0);
      chk("wd_latency", 128'(cyc - start_cyc), 128'd22);
      wait_drain();
      stuck    = 1'b0;
      busy_len = 4;
      ns       = n_start;
      push(1, 100'd28, 0);
      do_req(1, 100'd5, 101'd3, 100'd97);
      wait_drain();
      chk("wd_restart", 128'(n_start), 128'(ns + 1));

      // Withheld response, non-owner ready ignored.
      busy_len      = 3;
      bus.rsp_ready = 2'b10;
      push(0, 100'd48573, 0);
      do_req(0, 100'd2, 101'd20, 100'd1000003);
      wait_valid(0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         bus.req_valid = 2'b11;
         @(negedge clk);
         chk("hold_valid", 128'(bus.rsp_valid), 128'd1);
         chk("hold_result", 128'(bus.rsp_result), 128'd48573);
         chk("hold_err", 128'(bus.rsp_err), 128'd0);
         chk("hold_req_ready", 128'(bus.req_ready), 128'd0);
      end
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b11;
      wait_drain();

      // Reset in RUN clears everything at once, no response.
      busy_len = 30;
      do_req(1, 100'd10, 101'd3, 100'd1000003);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("mid_rsp_valid", 128'(bus.rsp_valid), 128'd0);
      chk("mid_req_ready", 128'(bus.req_ready), 128'd0);
      chk("mid_eng_start", 128'(eng_start), 128'd0);
      chk("mid_eng_base", 128'(eng_base), 128'd0);
      chk("mid_eng_exp", 128'(eng_exp), 128'd0);
      chk("mid_result", 128'(bus.rsp_result), 128'd0);
      chk("mid_err", 128'(bus.rsp_err), 128'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      busy_len = 5;
      push(1, 100'd1000, 0);
      do_req(1, 100'd10, 101'd3, 100'd1000003);
      wait_drain();

      repeat (5) @(negedge clk);
      chk("sb_empty", 128'(sb.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
